// File: rtl/dac_spi_pkg.sv
// Shared constants, state encoding and frame builder for the LTC2624 SPI master.
package dac_spi_pkg;

    localparam int FRAME_W  = 32;
    localparam int CMD_MSB  = 23;
    localparam int ADDR_MSB = 19;
    localparam int DATA_MSB = 15;

    localparam int DIV_DEFAULT = 2;
    localparam int GAP_DEFAULT = 2;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SHIFT_LO = 3'd1;
    localparam logic [2:0] ST_SHIFT_HI = 3'd2;
    localparam logic [2:0] ST_TAIL     = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;

    typedef logic [FRAME_W-1:0] frame_t;

    // Frame layout: {8'h00, command, address, data, 4'h0}, sent MSB first.
    function automatic frame_t build_frame(input logic [3:0]  cmd,
                                           input logic [3:0]  addr,
                                           input logic [11:0] code);
        frame_t f;
        f = '0;
        f[CMD_MSB  -: 4]  = cmd;
        f[ADDR_MSB -: 4]  = addr;
        f[DATA_MSB -: 12] = code;
        return f;
    endfunction

endpackage

// File: rtl/dac_spi_tick.sv
// Phase timer: load a cycle count minus one, tick is high on the last cycle of the phase.
module dac_spi_tick
    import dac_spi_pkg::*;
(
    input  logic       CLK50MHZ,
    input  logic       RST,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       tick
);

    logic [7:0] cnt;

    // Count down to zero and park there until the next load.
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign tick = (cnt == 8'd0);

endmodule

// File: rtl/dac_spi_master.sv
// SPI master for the LTC2624 quad DAC: one 32-bit frame out on MOSI per trigger,
// with the DAC's SDO word captured in parallel.
module dac_spi_master
    import dac_spi_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT,
    parameter int GAP = GAP_DEFAULT
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic [11:0] data,
    input  logic [3:0]  address,
    input  logic [3:0]  command,
    input  logic        dactrig,
    output logic        dacdone,
    output logic [31:0] dac_datareceived,
    output logic        busy,
    output logic        SPI_SCK,
    output logic        SPI_MOSI,
    output logic        DAC_CS,
    output logic        DAC_CLR,
    input  logic        DAC_OUT
);

    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);
    // The IDLE cycle before the next acceptance is itself one of the CS-high gap
    // cycles, so the GAP state only needs to cover the remaining GAP-1 cycles.
    localparam logic [7:0] GAP_LOAD = (GAP >= 2) ? 8'(GAP - 2) : 8'd0;

    logic [2:0]  state;
    logic [4:0]  bit_cnt;
    frame_t      frame_in;
    frame_t      tx_sr;
    frame_t      rx_sr;
    logic        tmr_load;
    logic [7:0]  tmr_val;
    logic        tick;

    assign frame_in = build_frame(command, address, data);

    dac_spi_tick u_tick (
        .CLK50MHZ (CLK50MHZ),
        .RST      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tick)
    );

    // Reload the phase timer on every phase change; TAIL hands over to the gap length.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = DIV_M1;
        case (state)
            ST_IDLE:     tmr_load = dactrig;
            ST_SHIFT_LO: tmr_load = tick;
            ST_SHIFT_HI: tmr_load = tick;
            ST_TAIL: begin
                tmr_load = tick;
                tmr_val  = GAP_LOAD;
            end
            default: ;
        endcase
    end

    // Frame FSM and all externally visible control outputs, each straight from a flop.
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            state            <= ST_IDLE;
            bit_cnt          <= 5'd0;
            SPI_SCK          <= 1'b0;
            SPI_MOSI         <= 1'b0;
            DAC_CS           <= 1'b1;
            busy             <= 1'b0;
            dacdone          <= 1'b0;
            dac_datareceived <= 32'd0;
        end else begin
            dacdone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dactrig) begin
                        state    <= ST_SHIFT_LO;
                        bit_cnt  <= 5'd31;
                        DAC_CS   <= 1'b0;
                        SPI_MOSI <= frame_in[FRAME_W-1];
                        busy     <= 1'b1;
                    end
                end
                ST_SHIFT_LO: begin
                    if (tick) begin
                        SPI_SCK <= 1'b1;
                        state   <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (tick) begin
                        SPI_SCK <= 1'b0;
                        if (bit_cnt != 5'd0) begin
                            bit_cnt  <= bit_cnt - 5'd1;
                            SPI_MOSI <= tx_sr[FRAME_W-2];
                            state    <= ST_SHIFT_LO;
                        end else begin
                            state <= ST_TAIL;
                        end
                    end
                end
                ST_TAIL: begin
                    if (tick) begin
                        DAC_CS           <= 1'b1;
                        dac_datareceived <= rx_sr;
                        dacdone          <= 1'b1;
                        if (GAP > 1) begin
                            state <= ST_GAP;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    SPI_SCK <= 1'b0;
                    DAC_CS  <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Transmit/receive shift registers; fully overwritten each frame so no reset is needed.
    always_ff @(posedge CLK50MHZ) begin
        if (state == ST_IDLE && dactrig) begin
            tx_sr <= frame_in;
        end else if (state == ST_SHIFT_HI && tick && bit_cnt != 5'd0) begin
            tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
        end
        if (state == ST_SHIFT_LO && tick) begin
            rx_sr <= {rx_sr[FRAME_W-2:0], DAC_OUT};
        end
    end

    // DAC clear is held while in reset and released on the first clock afterwards.
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            DAC_CLR <= 1'b0;
        end else begin
            DAC_CLR <= 1'b1;
        end
    end

endmodule
